// File: rtl/writeback_unit.sv
// writeback_unit: in-order writeback queue arbitrating a memory port and an ALU
// port onto a shared scalar/vector register-file write port. Tracks per-register
// pending-write masks and queue occupancy.
// Optional feature: define WB_BYPASS_EN to let a result accepted into an empty,
// unstalled queue write the register file in its acceptance cycle.

// Per-lane select between the queue head and the bypassed incoming lane.
module wb_lane_sel #(
    parameter int W = 8
) (
    input  logic         sel_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);
    assign y_o = sel_i ? b_i : a_i;
endmodule

module writeback_unit #(
    parameter int SCALAR_DATA_WIDTH = 48,
    parameter int VECTOR_DATA_WIDTH = 8,
    parameter int VECTOR_SIZE       = 6,
    parameter int ADDRESS_WIDTH     = 4,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic                                            memValid,
    output logic                                            memReady,
    input  logic                                            memIsVector,
    input  logic [ADDRESS_WIDTH-1:0]                        memAddress,
    input  logic [SCALAR_DATA_WIDTH-1:0]                    memScalarData,
    input  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]   memVectorData,
    input  logic                                            aluValid,
    output logic                                            aluReady,
    input  logic                                            aluIsVector,
    input  logic [ADDRESS_WIDTH-1:0]                        aluAddress,
    input  logic [SCALAR_DATA_WIDTH-1:0]                    aluScalarData,
    input  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]   aluVectorData,
    input  logic                                            writeStall,
    output logic                                            writeEnableScalar,
    output logic                                            writeEnableVector,
    output logic [ADDRESS_WIDTH-1:0]                        writeAddress,
    output logic [SCALAR_DATA_WIDTH-1:0]                    writeScalarData,
    output logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]   writeVectorData,
    output logic [15:0]                                     pendingScalar,
    output logic [15:0]                                     pendingVector,
    output logic [$clog2(FIFO_DEPTH):0]                     count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic                                          is_vec;
        logic [ADDRESS_WIDTH-1:0]                      addr;
        logic [SCALAR_DATA_WIDTH-1:0]                  sdata;
        logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0] vdata;
    } wb_entry_t;

    wb_entry_t              fifo_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    wb_entry_t head;
    wb_entry_t in_ent;
    logic      full_s, empty_s;
    logic      acc_mem, acc_alu, acc_any;
    logic      pop_s, push_s, byp_s;

    assign full_s  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_s = (count_q == '0);

    // Memory port wins; the ALU is only offered a slot when memory is idle.
    assign memReady = !full_s;
    assign aluReady = !full_s && !memValid;
    assign acc_mem  = memValid && !full_s;
    assign acc_alu  = aluValid && !full_s && !memValid;
    assign acc_any  = acc_mem || acc_alu;

    // Incoming entry from whichever port is accepted this cycle.
    always_comb begin
        in_ent = '0;
        if (acc_mem) begin
            in_ent.is_vec = memIsVector;
            in_ent.addr   = memAddress;
            in_ent.sdata  = memScalarData;
            in_ent.vdata  = memVectorData;
        end else begin
            in_ent.is_vec = aluIsVector;
            in_ent.addr   = aluAddress;
            in_ent.sdata  = aluScalarData;
            in_ent.vdata  = aluVectorData;
        end
    end

`ifdef WB_BYPASS_EN
    // Bypass stays off until one edge after reset release so a freshly reset
    // unit never strobes the register file in its first live cycle.
    logic live_q;

    // Arm the bypass path one clock after reset deasserts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) live_q <= 1'b0;
        else        live_q <= 1'b1;
    end

    assign byp_s = acc_any && empty_s && !writeStall && live_q;
`else
    assign byp_s = 1'b0;
`endif

    assign pop_s  = !empty_s && !writeStall;
    assign push_s = acc_any && !byp_s;
    assign head   = fifo_q[rptr_q];

    // Next-state for pointers, occupancy and per-entry valid flags.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        valid_d = valid_q;
        count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        if (pop_s) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = rptr_q + PTR_W'(1);
        end
        if (push_s) begin
            valid_d[wptr_q] = 1'b1;
            wptr_d          = wptr_q + PTR_W'(1);
        end
    end

    // Queue control state; reset empties the queue and drops all entries.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Payload storage; contents are qualified by valid_q so no reset needed.
    always_ff @(posedge clock) begin
        if (push_s) fifo_q[wptr_q] <= in_ent;
    end

    // Pending masks: OR of every live entry, head included while it writes.
    always_comb begin
        pendingScalar = '0;
        pendingVector = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            for (int a = 0; a < 16; a++) begin
                if (valid_q[i] && (int'(fifo_q[i].addr) == a)) begin
                    if (fifo_q[i].is_vec) pendingVector[a] = 1'b1;
                    else                  pendingScalar[a] = 1'b1;
                end
            end
        end
    end

    // Register-file write port: head on a pop, incoming entry on a bypass.
    always_comb begin
        writeEnableScalar = (pop_s && !head.is_vec) || (byp_s && !in_ent.is_vec);
        writeEnableVector = (pop_s &&  head.is_vec) || (byp_s &&  in_ent.is_vec);
        writeAddress      = byp_s ? in_ent.addr  : head.addr;
        writeScalarData   = byp_s ? in_ent.sdata : head.sdata;
    end

    for (genvar l = 0; l < VECTOR_SIZE; l++) begin : g_lane
        wb_lane_sel #(.W(VECTOR_DATA_WIDTH)) u_sel (
            .sel_i (byp_s),
            .a_i   (head.vdata[l]),
            .b_i   (in_ent.vdata[l]),
            .y_o   (writeVectorData[l])
        );
    end

    assign count = count_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: every accepted result is queued as an
// expected write and matched against the register-file write port.
module tb_writeback_unit;
    localparam int SW = 48;
    localparam int VW = 8;
    localparam int VS = 6;
    localparam int AW = 4;
    localparam int D  = 4;

    logic clock = 1'b0;
    logic reset;
    logic memValid, memReady, memIsVector;
    logic [AW-1:0] memAddress;
    logic [SW-1:0] memScalarData;
    logic [VS-1:0][VW-1:0] memVectorData;
    logic aluValid, aluReady, aluIsVector;
    logic [AW-1:0] aluAddress;
    logic [SW-1:0] aluScalarData;
    logic [VS-1:0][VW-1:0] aluVectorData;
    logic writeStall;
    logic writeEnableScalar, writeEnableVector;
    logic [AW-1:0] writeAddress;
    logic [SW-1:0] writeScalarData;
    logic [VS-1:0][VW-1:0] writeVectorData;
    logic [15:0] pendingScalar, pendingVector;
    logic [$clog2(D):0] count;

    writeback_unit #(
        .SCALAR_DATA_WIDTH(SW), .VECTOR_DATA_WIDTH(VW), .VECTOR_SIZE(VS),
        .ADDRESS_WIDTH(AW), .FIFO_DEPTH(D)
    ) dut (
        .clock(clock), .reset(reset),
        .memValid(memValid), .memReady(memReady), .memIsVector(memIsVector),
        .memAddress(memAddress), .memScalarData(memScalarData), .memVectorData(memVectorData),
        .aluValid(aluValid), .aluReady(aluReady), .aluIsVector(aluIsVector),
        .aluAddress(aluAddress), .aluScalarData(aluScalarData), .aluVectorData(aluVectorData),
        .writeStall(writeStall),
        .writeEnableScalar(writeEnableScalar), .writeEnableVector(writeEnableVector),
        .writeAddress(writeAddress), .writeScalarData(writeScalarData),
        .writeVectorData(writeVectorData),
        .pendingScalar(pendingScalar), .pendingVector(pendingVector), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          isv;
        logic [AW-1:0] addr;
        logic [63:0]   data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Vector payload is the inverse of the scalar seed so a swapped data path shows up.
    function automatic logic [63:0] pay(input logic isv, input logic [63:0] d);
        logic [47:0] s;
        s = d[47:0];
        return isv ? {16'h0, ~s} : {16'h0, s};
    endfunction

    task automatic set_mem(input logic v, input logic isv, input logic [AW-1:0] a, input logic [63:0] d);
        memValid = v; memIsVector = isv; memAddress = a;
        memScalarData = d[SW-1:0]; memVectorData = ~d[SW-1:0];
    endtask

    task automatic set_alu(input logic v, input logic isv, input logic [AW-1:0] a, input logic [63:0] d);
        aluValid = v; aluIsVector = isv; aluAddress = a;
        aluScalarData = d[SW-1:0]; aluVectorData = ~d[SW-1:0];
    endtask

    function automatic void expect_wr(input logic isv, input logic [AW-1:0] a, input logic [63:0] d);
        exp_t e;
        e.isv = isv; e.addr = a; e.data = pay(isv, d);
        sb.push_back(e);
    endfunction

    // Write-port monitor: each strobe must match the oldest expected write.
    exp_t me;
    always @(negedge clock) begin
        if (writeEnableScalar || writeEnableVector) begin
            if (sb.size() == 0) begin
                chk("wr_unexpected", 64'd1, 64'd0);
            end else begin
                me = sb.pop_front();
                chk("wr_both", 64'(writeEnableScalar && writeEnableVector), 64'd0);
                chk("wr_kind", 64'(writeEnableVector), 64'(me.isv));
                chk("wr_addr", 64'(writeAddress), 64'(me.addr));
                chk("wr_data", me.isv ? 64'(writeVectorData) : 64'(writeScalarData), me.data);
            end
        end
    end

    int          cnt_m;
    logic        mv, av, isv, am, aa, pop_m, byp_m;
    logic [63:0] r;

    initial begin
        reset = 1'b0; writeStall = 1'b0;
        set_mem(0, 0, '0, '0);
        set_alu(0, 0, '0, '0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_pend_s", 64'(pendingScalar), 64'd0);
        chk("rst_pend_v", 64'(pendingVector), 64'd0);
        chk("rst_we", 64'({writeEnableScalar, writeEnableVector}), 64'd0);
        chk("rst_ready", 64'({memReady, aluReady}), 64'd3);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_we", 64'({writeEnableScalar, writeEnableVector}), 64'd0);
        tick;

        // Single ALU scalar write through an empty queue
        set_alu(1, 0, 4'd3, 64'h0000_0000_ABCD);
        expect_wr(0, 4'd3, 64'h0000_0000_ABCD);
        @(negedge clock);
        chk("t1_alu_ready", 64'(aluReady), 64'd1);
`ifdef WB_BYPASS_EN
        chk("t1_byp_we", 64'(writeEnableScalar), 64'd1);
        chk("t1_byp_count", 64'(count), 64'd0);
        tick;
        set_alu(0, 0, '0, '0);
        @(negedge clock);
        chk("t1_byp_count2", 64'(count), 64'd0);
`else
        chk("t1_count0", 64'(count), 64'd0);
        tick;
        set_alu(0, 0, '0, '0);
        @(negedge clock);
        chk("t1_count1", 64'(count), 64'd1);
        chk("t1_we", 64'(writeEnableScalar), 64'd1);
        chk("t1_addr", 64'(writeAddress), 64'd3);
        tick;
        @(negedge clock);
        chk("t1_count_end", 64'(count), 64'd0);
        chk("t1_we_end", 64'(writeEnableScalar), 64'd0);
`endif
        tick;

        // Both ports valid together: memory first, ALU waits
        set_mem(1, 1, 4'd5, 64'h1234_5678_9ABC);
        set_alu(1, 0, 4'd6, 64'h0000_0000_0066);
        expect_wr(1, 4'd5, 64'h1234_5678_9ABC);
        expect_wr(0, 4'd6, 64'h0000_0000_0066);
        @(negedge clock);
        chk("t2_alu_ready", 64'(aluReady), 64'd0);
        chk("t2_mem_ready", 64'(memReady), 64'd1);
        tick;
        set_mem(0, 0, '0, '0);
`ifndef WB_BYPASS_EN
        @(negedge clock);
        chk("t2_we_vec", 64'({writeEnableScalar, writeEnableVector}), 64'd1);
`endif
        tick;
        set_alu(0, 0, '0, '0);
`ifndef WB_BYPASS_EN
        @(negedge clock);
        chk("t2_we_sca", 64'({writeEnableScalar, writeEnableVector}), 64'd2);
`endif
        tick;
        @(negedge clock);
        chk("t2_count_end", 64'(count), 64'd0);
        tick;

        // Fill under stall, full back-pressure, then ordered drain
        writeStall = 1'b1;
        for (int a = 1; a <= 4; a++) begin
            set_alu(1, 0, AW'(a), 64'(32'h100 + a));
            expect_wr(0, AW'(a), 64'(32'h100 + a));
            tick;
        end
        set_alu(1, 0, 4'd9, 64'h999);
        @(negedge clock);
        chk("t3_count_full", 64'(count), 64'd4);
        chk("t3_ready_full", 64'({memReady, aluReady}), 64'd0);
        chk("t3_pend", 64'(pendingScalar), 64'h001E);
        chk("t3_stall_we", 64'({writeEnableScalar, writeEnableVector}), 64'd0);
        tick;
        set_alu(0, 0, '0, '0);
        writeStall = 1'b0;
        set_mem(1, 0, 4'd10, 64'hA0A);
        expect_wr(0, 4'd10, 64'hA0A);
        @(negedge clock);
        chk("t3_full_still", 64'(count), 64'd4);
        chk("t3_mem_ready_popfull", 64'(memReady), 64'd0);
        chk("t3_pend_head", 64'(pendingScalar), 64'h001E);
        tick;
        @(negedge clock);
        chk("t3_count3", 64'(count), 64'd3);
        chk("t3_mem_ready", 64'(memReady), 64'd1);
        chk("t3_pend2", 64'(pendingScalar), 64'h001C);
        tick;
        set_mem(0, 0, '0, '0);
        @(negedge clock);
        chk("t3_pushpop", 64'(count), 64'd3);
        chk("t3_pend3", 64'(pendingScalar), 64'h0418);
        repeat (3) tick;
        @(negedge clock);
        chk("t3_count_end", 64'(count), 64'd0);
        chk("t3_pend_end", 64'(pendingScalar), 64'd0);
        tick;

        // Repeated writes to one register keep order
        writeStall = 1'b1;
        set_alu(1, 0, 4'd7, 64'd1); expect_wr(0, 4'd7, 64'd1); tick;
        set_alu(1, 0, 4'd7, 64'd2); expect_wr(0, 4'd7, 64'd2); tick;
        set_alu(0, 0, '0, '0);
        @(negedge clock);
        chk("t4_count", 64'(count), 64'd2);
        chk("t4_pend7a", 64'(pendingScalar), 64'h0080);
        tick;
        writeStall = 1'b0;
        @(negedge clock);
        chk("t4_pend7b", 64'(pendingScalar[7]), 64'd1);
        tick;
        @(negedge clock);
        chk("t4_pend7c", 64'(pendingScalar[7]), 64'd1);
        tick;
        @(negedge clock);
        chk("t4_pend7d", 64'(pendingScalar[7]), 64'd0);
        tick;

        // Asynchronous reset with entries queued
        writeStall = 1'b1;
        set_alu(1, 0, 4'd1, 64'h11); tick;
        set_alu(1, 1, 4'd2, 64'h22); tick;
        set_alu(1, 0, 4'd3, 64'h33); tick;
        set_alu(0, 0, '0, '0);
        @(negedge clock);
        chk("t5_count3", 64'(count), 64'd3);
        chk("t5_pend_v", 64'(pendingVector), 64'h0004);
        #2;
        reset = 1'b0;
        writeStall = 1'b0;
        #1;
        chk("t5_async_count", 64'(count), 64'd0);
        chk("t5_async_pend_s", 64'(pendingScalar), 64'd0);
        chk("t5_async_pend_v", 64'(pendingVector), 64'd0);
        chk("t5_async_we", 64'({writeEnableScalar, writeEnableVector}), 64'd0);
        tick;
        reset = 1'b1;
        @(negedge clock);
        chk("t5_post_we", 64'({writeEnableScalar, writeEnableVector}), 64'd0);
        chk("t5_post_count", 64'(count), 64'd0);
        tick;

        // Random traffic against an occupancy model
        cnt_m = 0;
        for (int c = 0; c < 80; c++) begin
            mv = 1'($urandom_range(0, 1));
            av = 1'($urandom_range(0, 1));
            writeStall = ($urandom_range(0, 3) == 0);
            r = {$urandom(), $urandom()};
            isv = r[50];
            set_mem(mv, isv, r[55:52], r);
            set_alu(av, ~isv, r[59:56], ~r);
            am = mv && (cnt_m < D);
            aa = av && (cnt_m < D) && !mv;
            if (am)      expect_wr(isv, r[55:52], r);
            else if (aa) expect_wr(~isv, r[59:56], ~r);
            @(negedge clock);
            chk("rnd_count", 64'(count), 64'(cnt_m));
            chk("rnd_mem_ready", 64'(memReady), 64'(cnt_m < D));
            chk("rnd_alu_ready", 64'(aluReady), 64'((cnt_m < D) && !mv));
            pop_m = (cnt_m > 0) && !writeStall;
`ifdef WB_BYPASS_EN
            byp_m = (am || aa) && (cnt_m == 0) && !writeStall;
`else
            byp_m = 1'b0;
`endif
            cnt_m = cnt_m + int'((am || aa) && !byp_m) - int'(pop_m);
            tick;
        end
        set_mem(0, 0, '0, '0);
        set_alu(0, 0, '0, '0);
        writeStall = 1'b0;
        for (int w = 0; w < 12 && sb.size() != 0; w++) tick;
        @(negedge clock);
        chk("drain_count", 64'(count), 64'd0);

`ifdef WB_BYPASS_EN
        // Zero-latency bypass into an empty queue
        tick;
        set_alu(1, 0, 4'd3, 64'hABCD);
        expect_wr(0, 4'd3, 64'hABCD);
        @(negedge clock);
        chk("t6_byp_we", 64'(writeEnableScalar), 64'd1);
        chk("t6_byp_pend", 64'(pendingScalar), 64'd0);
        tick;
        set_alu(0, 0, '0, '0);
        @(negedge clock);
        chk("t6_byp_count", 64'(count), 64'd0);
`endif
        tick;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter SCALAR_DATA_WIDTH, default 48, scalar register data width.
REQ-002 SHALL have parameter VECTOR_DATA_WIDTH, default 8, vector lane width.
REQ-003 SHALL have parameter VECTOR_SIZE, default 6, lanes per vector.
REQ-004 SHALL have parameter ADDRESS_WIDTH, default 4, register address width (16 registers per file).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, power of two, writeback queue entries.
REQ-006 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-008 SHALL have ports memValid/aluValid, input, 1 each, producer offers a result.
REQ-009 SHALL have ports memReady/aluReady, output, 1 each, result accepted on the edge where valid and ready are both high.
REQ-010 SHALL have ports memIsVector/aluIsVector, input, 1 each, destination file select (1 = vector).
REQ-011 SHALL have ports memAddress/aluAddress, input, ADDRESS_WIDTH each, destination register.
REQ-012 SHALL have ports memScalarData/aluScalarData, input, SCALAR_DATA_WIDTH each, scalar result.
REQ-013 SHALL have ports memVectorData/aluVectorData, input, VECTOR_SIZE x VECTOR_DATA_WIDTH packed each, vector result.
REQ-014 SHALL have port writeStall, input, 1, inhibits register-file writes this cycle.
REQ-015 SHALL have ports writeEnableScalar, writeEnableVector, output, 1 each, register-file write strobes.
REQ-016 SHALL have ports writeAddress (ADDRESS_WIDTH), writeScalarData (SCALAR_DATA_WIDTH), writeVectorData (VECTOR_SIZE x VECTOR_DATA_WIDTH), outputs, register-file write payload.
REQ-017 SHALL have ports pendingScalar, pendingVector, output, 16 each, bit a set while a queued write targets register a.
REQ-018 SHALL have port count, output, log2(FIFO_DEPTH)+1, current queue occupancy.

Function
REQ-019 SHALL accept at most one result per cycle into an in-order FIFO; memory port has priority.
REQ-020 SHALL drive memReady = !full, aluReady = !full && !memValid; no push when full, even if popping same cycle.
REQ-021 SHALL pop the head every cycle where queue non-empty and writeStall low.
REQ-022 SHALL drive write outputs combinationally from head: writeEnableScalar = pop && !isVector, writeEnableVector = pop && isVector, payload from head entry.
REQ-023 SHALL hold both enables low when empty or writeStall high; payload don't-care then.
REQ-024 SHALL give a result accepted at edge N its write strobe during cycle N+1 if the queue was empty and no stall.
REQ-025 SHALL preserve acceptance order, including repeated writes to one address (last accepted wins).
REQ-026 SHALL compute pendingScalar/pendingVector as OR over all valid entries, including head being written this cycle.
REQ-027 SHALL update count by +1 on push, -1 on pop, unchanged on simultaneous push and pop; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-028 SHALL on reset low: empty queue, pointers zero, count 0, pending masks 0, write enables 0, readies 1.
REQ-029 SHALL discard queued entries on reset mid-operation; no write strobe asserted during or the cycle after reset release.

Configuration
REQ-030 SHALL, with WB_BYPASS_EN defined, write an accepted result in its acceptance cycle when queue empty and writeStall low, without enqueueing (zero latency, pending bits not set).
REQ-031 SHALL, without WB_BYPASS_EN, route every result through the queue per REQ-024.

Verification
REQ-032 SHALL test: aluValid, scalar addr 3, data 0x00000000ABCD, empty queue -> writeEnableScalar=1, writeAddress=3 next cycle; count 1 then 0.
REQ-033 SHALL test: memValid and aluValid together (mem addr 5 vector, alu addr 6 scalar) -> aluReady=0; vector write to 5 then scalar write to 6 on consecutive cycles.
REQ-034 SHALL test: writeStall high, 4 pushes to addrs 1,2,3,4 -> count=4, readies 0, pendingScalar=0x001E; stall released -> four writes in order, mask clears to 0.
REQ-035 SHALL test: two pushes to scalar addr 7 (data 1 then 2), stall held -> written 1 then 2; pendingScalar bit 7 high until second write.
REQ-036 SHALL test: reset asserted with count=3 -> count=0, no strobes, pending masks 0 immediately (asynchronous).
REQ-037 SHALL test with WB_BYPASS_EN: aluValid to empty queue -> writeEnableScalar in the same cycle, count stays 0.
